// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the IF->ID fetch queue.
//   FQ_DEPTH / FQ_PTR_W : default queue depth and pointer width
//   fq_entry_t          : packed {pc, instr} queue entry
//   FQ_EMPTY_ENTRY      : all-zero entry shown on the ID side while empty
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_PTR_W = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam fq_entry_t FQ_EMPTY_ENTRY = '0;

endpackage

// File: rtl/fetchq_mem.sv
// -----------------------------------------------------------------------------
// fetchq_mem
// DEPTH x W register array backing the fetch queue. No reset on storage;
// validity of each slot is tracked by the pointers/count in fetch_queue.
// Ports:
//   CLK      : rising-edge clock
//   i_we     : write enable (synchronous write)
//   i_waddr  : write slot
//   i_wdata  : write data
//   i_raddr  : read slot
//   o_rdata  : asynchronous read data
// -----------------------------------------------------------------------------
module fetchq_mem #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 64
) (
  input  logic             CLK,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Decoupling instruction queue between IF and ID. Captures {PC, instruction}
// pairs from IF and presents them to ID in program order via valid/ready.
// A flush (taken branch) discards all queued entries.
//
// Optional feature (macro FETCHQ_BYPASS_EN): when the queue is empty, an
// incoming IF entry is forwarded combinationally to the ID outputs; if ID
// takes it in the same cycle it is never written into the queue.
//
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   if_valid        : IF presents an entry
//   if_pc           : PC of the fetched instruction
//   if_instruction  : fetched instruction word
//   if_ready        : queue can accept a push (occupancy only)
//   flush           : discard all entries at the next edge
//   id_ready        : ID consumes the head entry
//   id_valid        : head entry valid
//   id_pc           : head PC (0 while empty)
//   id_instruction  : head instruction (0 while empty)
//   count           : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = 32,
  parameter int PTR_W  = FQ_PTR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instruction,
  output logic              if_ready,
  input  logic              flush,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instruction,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W:0]      r_count;

  logic                w_stored;
  logic                w_bypass;
  logic                w_bypass_take;
  logic                w_push;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_head;

  assign w_stored = (r_count != '0);
  assign if_ready = (r_count != LP_FULL);

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass      = ~w_stored & if_valid & ~flush;
  assign w_bypass_take = w_bypass & id_ready;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  // A bypassed entry consumed directly by ID never touches the storage.
  assign w_push = if_valid & if_ready & ~flush & ~w_bypass_take;
  // Pop only moves the read pointer for entries actually stored.
  assign w_pop  = w_stored & id_ready & ~flush;

  fetchq_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (2*DATA_W)
  ) u_mem (
    .CLK     (CLK),
    .i_we    (w_push & ~RST),
    .i_waddr (r_wr_ptr),
    .i_wdata ({if_pc, if_instruction}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_comb begin
    id_valid       = w_stored | w_bypass;
    id_pc          = '0;
    id_instruction = '0;
    if (w_stored) begin
      id_pc          = w_head[2*DATA_W-1:DATA_W];
      id_instruction = w_head[DATA_W-1:0];
    end else if (w_bypass) begin
      id_pc          = if_pc;
      id_instruction = if_instruction;
    end
  end

  assign count = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
